// File: rtl/noc_output_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : noc_output_port_arbiter
// Description : Wormhole output-port arbiter, two-class round-robin with
//               starvation timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module noc_output_port_arbiter #(
   parameter int NPORT   = 5,
   parameter int TIMEOUT = 64,
   parameter int CW      = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NPORT-1:0]   req,
   input  logic [NPORT-1:0]   prio,
   input  logic [3*NPORT-1:0] flit_type,
   input  logic               out_ready,
   output logic [NPORT-1:0]   bussy,
   output logic [NPORT-1:0]   grant,
   output logic [2:0]         out_sel,
   output logic               out_valid,
   output logic               locked,
   output logic               timeout_err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   localparam logic [3:0]       C_NPORT   = 4'(NPORT);
   localparam logic [2:0]       C_LAST    = 3'(NPORT - 1);
   localparam logic [NPORT-1:0] C_ONE     = NPORT'(1);
   localparam logic [CW-1:0]    C_TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [2:0]       C_TAIL    = 3'b001;
   localparam logic [2:0]       C_SINGLE  = 3'b110;

   state_t           r_state;
   logic [2:0]       r_prio_ptr;
   logic [2:0]       r_reg_ptr;
   logic [CW-1:0]    r_cnt;
   logic [NPORT-1:0] r_grant;
   logic [2:0]       r_sel;
   logic             r_err;

   logic [NPORT-1:0] w_pmask;
   logic             w_use_prio;
   logic [2:0]       w_win;
   logic [2:0]       w_win_next;
   logic [NPORT-1:0] w_onehot;
   logic             w_cur_req;
   logic [2:0]       w_cur_type;
   logic             w_xfer;
   logic             w_tail;
   logic             w_starve;

   // First set bit of vec at or after ptr, scanning circularly.
   function automatic logic [2:0] rr_pick(input logic [NPORT-1:0] vec,
                                          input logic [2:0]       ptr);
      logic [7:0] v;
      logic [3:0] idx;
      logic       found;
      v       = 8'(vec);
      found   = 1'b0;
      rr_pick = 3'd0;
      for (int k = 0; k < NPORT; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= C_NPORT)
            idx = idx - C_NPORT;
         if (!found && v[idx[2:0]]) begin
            found   = 1'b1;
            rr_pick = idx[2:0];
         end
      end
   endfunction

   assign w_pmask    = req & prio;
   assign w_use_prio = |w_pmask;
   assign w_win      = w_use_prio ? rr_pick(w_pmask, r_prio_ptr) : rr_pick(req, r_reg_ptr);
   assign w_win_next = (w_win == C_LAST) ? 3'd0 : w_win + 3'd1;
   assign w_onehot   = C_ONE << w_win;

   always_comb begin
      w_cur_type = 3'b000;
      for (int i = 0; i < NPORT; i++)
         w_cur_type = w_cur_type | (flit_type[3*i +: 3] & {3{r_grant[i]}});
   end

   assign w_cur_req = |(req & r_grant);
   assign w_xfer    = (r_state == ST_LOCK) & w_cur_req & out_ready;
   assign w_starve  = (r_state == ST_LOCK) & ~w_cur_req & out_ready;
   assign w_tail    = (w_cur_type == C_TAIL) | (w_cur_type == C_SINGLE);

   // Grant is all-zero outside a lock, so every input stalls while idle.
   assign bussy       = ~(r_grant & {NPORT{out_ready}});
   assign grant       = r_grant;
   assign out_sel     = r_sel;
   assign out_valid   = w_xfer;
   assign locked      = (r_state == ST_LOCK);
   assign timeout_err = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_prio_ptr <= 3'd0;
         r_reg_ptr  <= 3'd0;
         r_cnt      <= '0;
         r_grant    <= '0;
         r_sel      <= 3'd0;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_grant <= w_onehot;
                  r_sel   <= w_win;
                  r_cnt   <= '0;
                  r_state <= ST_LOCK;
                  if (w_use_prio)
                     r_prio_ptr <= w_win_next;
                  else
                     r_reg_ptr  <= w_win_next;
               end
            end
            ST_LOCK: begin
               if (w_xfer) begin
                  r_cnt <= '0;
                  if (w_tail) begin
                     r_state <= ST_IDLE;
                     r_grant <= '0;
                     r_sel   <= 3'd0;
                  end
               end else if (w_starve) begin
                  // Owner has nothing to send although downstream is ready.
                  if (r_cnt == C_TO_LAST) begin
                     r_state <= ST_IDLE;
                     r_grant <= '0;
                     r_sel   <= 3'd0;
                     r_cnt   <= '0;
                     r_err   <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_noc_output_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_noc_output_port_arbiter
// Description : Randomized scoreboard bench for noc_output_port_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_noc_output_port_arbiter;

   localparam int NPORT   = 5;
   localparam int TIMEOUT = 64;
   localparam int CW      = 7;

   logic               clk = 1'b0;
   logic               rst;
   logic [NPORT-1:0]   req;
   logic [NPORT-1:0]   prio;
   logic [3*NPORT-1:0] flit_type;
   logic               out_ready;
   logic [NPORT-1:0]   bussy;
   logic [NPORT-1:0]   grant;
   logic [2:0]         out_sel;
   logic               out_valid;
   logic               locked;
   logic               timeout_err;

   noc_output_port_arbiter #(.NPORT(NPORT), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .prio        (prio),
      .flit_type   (flit_type),
      .out_ready   (out_ready),
      .bussy       (bussy),
      .grant       (grant),
      .out_sel     (out_sel),
      .out_valid   (out_valid),
      .locked      (locked),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             valid;
      logic [2:0]       sel;
      logic [NPORT-1:0] grant;
      logic [NPORT-1:0] bussy;
      logic             locked;
      logic             err;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   total = 0;
   int   bad   = 0;
   int   n_xfer = 0;
   int   n_timeout = 0;

   // Reference model: owner index (-1 idle), class pointers, starve count.
   int owner = -1;
   int prio_ptr = 0;
   int reg_ptr = 0;
   int starve = 0;
   bit err_next = 1'b0;

   // Upstream packet generators, one per input.
   int         len  [NPORT];
   int         pos  [NPORT];
   logic [2:0] body [NPORT];

   function automatic logic [2:0] rand_body();
      case ($urandom_range(0, 4))
         0: return 3'b000;
         1: return 3'b011;
         2: return 3'b111;
         3: return 3'b101;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [2:0] cur_type(int i);
      if (len[i] == 1)          return 3'b110;
      if (pos[i] == 0)          return 3'b100;
      if (pos[i] == len[i] - 1) return 3'b001;
      return body[i];
   endfunction

   task automatic new_pkt(int i);
      len[i]  = $urandom_range(1, 4);
      pos[i]  = 0;
      body[i] = rand_body();
   endtask

   task automatic advance(int i);
      pos[i]  = pos[i] + 1;
      body[i] = rand_body();
      if (pos[i] >= len[i])
         new_pkt(i);
   endtask

   function automatic int first_from(logic [NPORT-1:0] vec, int ptr);
      for (int k = 0; k < NPORT; k++) begin
         if (vec[(ptr + k) % NPORT])
            return (ptr + k) % NPORT;
      end
      return -1;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // mode 0: random traffic, 1: owner starves, 2: heavy backpressure
   task automatic step(int mode);
      exp_t             e;
      logic [NPORT-1:0] p;
      logic [2:0]       t;
      int               w;
      @(posedge clk);
      #2;
      for (int i = 0; i < NPORT; i++) begin
         req[i]  = ($urandom_range(0, 9) < 7);
         prio[i] = ($urandom_range(0, 9) < 3);
         flit_type[3*i +: 3] = cur_type(i);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (mode == 1) begin
         out_ready = 1'b1;
         if (owner >= 0)
            req[owner] = 1'b0;
      end
      if (mode == 2)
         out_ready = ($urandom_range(0, 99) < 15);

      e.locked = (owner >= 0);
      e.grant  = (owner >= 0) ? (NPORT'(1) << owner) : '0;
      e.sel    = (owner >= 0) ? 3'(owner) : 3'd0;
      e.valid  = (owner >= 0) && req[owner] && out_ready;
      e.bussy  = '1;
      if (owner >= 0 && out_ready)
         e.bussy[owner] = 1'b0;
      e.err    = err_next;
      q.push_back(e);

      err_next = 1'b0;
      if (owner < 0) begin
         if (req != '0) begin
            p = req & prio;
            if (p != '0) begin
               w = first_from(p, prio_ptr);
               prio_ptr = (w + 1) % NPORT;
            end else begin
               w = first_from(req, reg_ptr);
               reg_ptr = (w + 1) % NPORT;
            end
            owner  = w;
            starve = 0;
         end
      end else if (e.valid) begin
         n_xfer++;
         t = cur_type(owner);
         advance(owner);
         starve = 0;
         if (t == 3'b001 || t == 3'b110)
            owner = -1;
      end else if (!req[owner] && out_ready) begin
         starve++;
         if (starve == TIMEOUT) begin
            owner    = -1;
            starve   = 0;
            err_next = 1'b1;
            n_timeout++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         me = q.pop_front();
         total++;
         if (out_valid !== me.valid || out_sel !== me.sel || grant !== me.grant ||
             bussy !== me.bussy || locked !== me.locked || timeout_err !== me.err) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t: got valid=%b sel=%0d grant=%b bussy=%b locked=%b err=%b, want valid=%b sel=%0d grant=%b bussy=%b locked=%b err=%b",
                     $time, out_valid, out_sel, grant, bussy, locked, timeout_err,
                     me.valid, me.sel, me.grant, me.bussy, me.locked, me.err);
         end
      end
   end

   initial begin
      int tries;
      rst       = 1'b1;
      req       = '0;
      prio      = '0;
      flit_type = '0;
      out_ready = 1'b0;
      for (int i = 0; i < NPORT; i++)
         new_pkt(i);

      repeat (2) @(posedge clk);
      #2;
      chk("reset_bussy", 32'(bussy), 32'h1f);
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_out_sel", 32'(out_sel), 32'h0);
      chk("reset_locked", 32'(locked), 32'h0);
      chk("reset_timeout_err", 32'(timeout_err), 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      rst = 1'b0;

      repeat (300) step(0);
      repeat (220) step(1);
      repeat (150) step(2);
      repeat (200) step(0);

      // Reach a locked state, then reset asynchronously in mid-cycle.
      tries = 0;
      while (owner < 0 && tries < 50) begin
         step(0);
         tries++;
      end
      chk("lock_before_async_reset", 32'(owner >= 0), 32'h1);
      @(posedge clk);
      #2;
      chk("locked_before_rst", 32'(locked), 32'(owner >= 0));
      rst = 1'b1;
      #1;
      chk("async_rst_grant", 32'(grant), 32'h0);
      chk("async_rst_bussy", 32'(bussy), 32'h1f);
      chk("async_rst_locked", 32'(locked), 32'h0);
      chk("async_rst_out_valid", 32'(out_valid), 32'h0);
      chk("async_rst_out_sel", 32'(out_sel), 32'h0);
      req = '0;
      repeat (2) @(posedge clk);
      #2;
      rst      = 1'b0;
      owner    = -1;
      prio_ptr = 0;
      reg_ptr  = 0;
      starve   = 0;
      err_next = 1'b0;

      repeat (150) step(0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'h0);
      chk("saw_transfers", 32'(n_xfer > 100), 32'h1);
      chk("saw_timeouts", 32'(n_timeout >= 2), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/noc_output_port_arbiter.md
Name: noc_output_port_arbiter

Overview:
- Arbitrates one router output port among NPORT input ports.
- Each input port's FIFO read controller presents a request, a priority-class select and the flit type at its FIFO head.
- Grants the port per packet (wormhole): locked from grant until the tail flit transfers.
- Drives each input's bussy stall line. Priority-class requests win over regular ones; round-robin within each class.

Parameters:
NPORT, 5, number of input ports competing for this output port (N/E/S/W/local)
TIMEOUT, 64, starved-lock cycles before forced release
CW, 7, timeout counter width (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NPORT  per-input request (FIFO non-empty)
prio  input  NPORT  per-input class: 1 = priority FIFO selected, 0 = regular
flit_type  input  3*NPORT  head flit type of port i at bits [3i+2:3i]
out_ready  input  1  downstream can accept a flit this cycle
bussy  output  NPORT  per-input stall; 0 lets that input read its FIFO
grant  output  NPORT  one-hot current owner, 0 when idle
out_sel  output  3  binary index of owner (crossbar select)
out_valid  output  1  a flit transfers this cycle
locked  output  1  port owned by a packet
timeout_err  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst=1): state IDLE; grant=0; out_sel=0; bussy all 1; out_valid=0; locked=0; timeout_err=0; both round-robin pointers=0; timeout counter=0.
- Flit type codes: 3'b100 head, 3'b010 body, 3'b001 tail, 3'b110 single-flit packet (head and tail). Other codes are treated as body.
- State IDLE:
  - bussy all 1; locked=0.
  - If any req: P = req & prio.
  - If P nonzero, the winner is the first set bit of P at or after prio_ptr, circularly. Otherwise the winner is the first set bit of req at or after reg_ptr.
  - At the clock edge: grant <= onehot(winner); out_sel <= winner; state <= LOCK; the winning class's pointer <= (winner+1) mod NPORT. The other pointer is unchanged.
- State LOCK:
  - locked=1; bussy[i]=1 for all i except the owner g.
  - bussy[g] = !out_ready.
  - xfer = req[g] & out_ready; out_valid = xfer (combinational).
  - If xfer and flit_type[g] is 3'b001 or 3'b110: at the edge, state <= IDLE, grant <= 0, counter <= 0.
  - If xfer on any other type: counter <= 0.
  - If !req[g] and out_ready: counter <= counter+1. When the counter reaches TIMEOUT-1 on such a cycle: state <= IDLE, grant <= 0, counter <= 0, timeout_err <= 1 for exactly one cycle.
  - out_ready=0 holds the counter and the lock.
- Latency and turnaround:
  - Request seen in IDLE → grant visible the next cycle.
  - First flit transfers that cycle if out_ready=1.
  - Release costs one IDLE bubble cycle before the next grant. Back-to-back packets from the same port re-arbitrate normally.
- No preemption: a priority request arriving during a regular-class lock waits for the tail.
- prio[g] changing during LOCK is ignored; the class is sampled only at grant.
- Single-flit packet (3'b110) transfers and releases in its grant cycle.
- rst asserted mid-packet: immediate return to reset values. Upstream FIFOs are not flushed by this block.
- out_sel and grant stay consistent at all times; grant is never multi-hot.

Test Plan:
- Reset then idle: rst pulse, req=0 → bussy=5'b11111, grant=0, locked=0, timeout_err=0.
- Single port, 4-flit packet: req[2]=1, prio=0, types 100,010,010,001, out_ready=1 → grant=5'b00100 one cycle later, out_sel=2, out_valid high 4 cycles, IDLE after tail.
- Priority over regular: req=5'b00011, prio=5'b00010, both single-flit → port 1 granted first, then port 0 after one bubble cycle. prio_ptr=2, reg_ptr=1 at end.
- Round-robin fairness: req=5'b11111 continuously, all regular single-flit packets → grant order 0,1,2,3,4,0 with one idle cycle between each.
- Backpressure and no preemption:
  - Port 3 (regular) locked mid-packet; out_ready=0 for 10 cycles; req[0] with prio=1 asserted.
  - Required: bussy[3]=1, out_valid=0, counter held, port 3 still owner.
  - After out_ready=1 and port 3's tail: port 0 granted.
- Timeout and async reset:
  - Port 4 locked after its head flit, then req[4]=0 with out_ready=1 → timeout_err pulses on cycle TIMEOUT, grant=0.
  - Separately, rst asserted mid-lock → outputs return to reset values without waiting for a clock edge.
